// File: rtl/uart_io_ctrl_if.sv
// AXI4-Lite bus between uart_io_ctrl (master) and the UART register block (slave).
// Only the fields the sequencer needs are carried; there is no PROT/ID signalling.
interface uart_io_ctrl_if;
   logic [3:0]  ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic [3:0]  AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   modport master (
      output ARADDR, ARVALID, input  ARREADY,
      input  RDATA, RRESP, RVALID, output RREADY,
      output AWADDR, AWVALID, input  AWREADY,
      output WDATA, WSTRB, WVALID, input  WREADY,
      input  BRESP, BVALID, output BREADY
   );

   modport slave (
      input  ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input  RREADY,
      input  AWADDR, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input  BREADY
   );
endinterface

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: sequences the core's one-byte in/out requests into
// status-poll + data-access transactions on an AXI4-Lite UART.
// UART map: 0x0 RX data, 0x4 TX data, 0x8 status (bit0 RX valid, bit3 TX full).
// Optional feature macro: UART_RX_PREFETCH_EN -- when defined, idle cycles are
// used to prefetch received bytes into a small FIFO so a buffered `in`
// completes in one cycle. Undefined (default): no FIFO, RX_LEVEL is 0.
module uart_io_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_REQ,
   output logic          IN_ACK,
   output logic [7:0]    IN_DATA,
   input  logic          OUT_REQ,
   input  logic [7:0]    OUT_DATA,
   output logic          OUT_ACK,
   output logic          BUSY,
   output logic          ERR,
   output logic [LW-1:0] RX_LEVEL,
   uart_io_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, S_AR, S_R, D_AR, D_R, W_AW, W_B, ACK
   } state_t;

   // Which request the current AXI sequence is serving.
   typedef enum logic [1:0] {
      OP_IN, OP_OUT, OP_PF
   } op_t;

   localparam logic [3:0] ADDR_RX   = 4'h0;
   localparam logic [3:0] ADDR_TX   = 4'h4;
   localparam logic [3:0] ADDR_STAT = 4'h8;

   state_t      state_q;
   op_t         op_q;
   logic        arvalid_q;
   logic [3:0]  araddr_q;
   logic        rready_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic [3:0]  awaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        bready_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic        in_ack_q;
   logic        out_ack_q;
   logic [7:0]  in_data_q;
   logic        err_q;

   // FIFO-facing decisions shared by the FSM and the buffer.
   logic        buf_hit;     // IDLE serves IN_REQ straight from the FIFO
   logic        pf_ok;       // IDLE may launch a background prefetch
   logic [7:0]  fifo_head;

   logic        ack_pend;
   logic        aw_hs;
   logic        w_hs;

   // An ACK pulse is in flight: the core's request is still high this cycle,
   // so IDLE must not treat it as a new one.
   assign ack_pend = in_ack_q | out_ack_q;
   assign aw_hs    = awvalid_q & bus.AWREADY;
   assign w_hs     = wvalid_q & bus.WREADY;

`ifdef UART_RX_PREFETCH_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          push;
   logic          pop;

   // Push only from a prefetch data read, pop only from IDLE: never both.
   assign push      = (state_q == D_R) && bus.RVALID && (op_q == OP_PF);
   assign pop       = buf_hit;
   assign buf_hit   = (state_q == IDLE) && !ack_pend && !OUT_REQ && IN_REQ &&
                      (level_q != '0);
   assign pf_ok     = (level_q != LW'(FIFO_DEPTH));
   assign fifo_head = mem_q[rd_ptr_q];
   assign RX_LEVEL  = level_q;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            level_q  <= level_q + LW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q  <= level_q - LW'(1);
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= bus.RDATA[7:0];
   end
`else
   assign buf_hit   = 1'b0;
   assign pf_ok     = 1'b0;
   assign fifo_head = 8'h00;
   assign RX_LEVEL  = '0;
`endif

   // Main sequencer: request arbitration, AXI channel control, ACK pulses.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         op_q      <= OP_IN;
         arvalid_q <= 1'b0;
         araddr_q  <= 4'h0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= 4'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         in_ack_q  <= 1'b0;
         out_ack_q <= 1'b0;
         in_data_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         in_ack_q  <= 1'b0;
         out_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!ack_pend) begin
                  if (OUT_REQ) begin
                     op_q      <= OP_OUT;
                     state_q   <= S_AR;
                     arvalid_q <= 1'b1;
                     araddr_q  <= ADDR_STAT;
                  end else if (buf_hit) begin
                     in_data_q <= fifo_head;
                     in_ack_q  <= 1'b1;
                  end else if (IN_REQ) begin
                     op_q      <= OP_IN;
                     state_q   <= S_AR;
                     arvalid_q <= 1'b1;
                     araddr_q  <= ADDR_STAT;
                  end else if (pf_ok) begin
                     op_q      <= OP_PF;
                     state_q   <= S_AR;
                     arvalid_q <= 1'b1;
                     araddr_q  <= ADDR_STAT;
                  end
               end
            end
            S_AR: begin
               if (bus.ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_R;
               end
            end
            S_R: begin
               if (bus.RVALID) begin
                  rready_q <= 1'b0;
                  if (bus.RRESP != 2'b00) err_q <= 1'b1;
                  if (op_q == OP_OUT) begin
                     if (bus.RDATA[3]) begin
                        state_q   <= S_AR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= ADDR_STAT;
                     end else begin
                        state_q   <= W_AW;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= ADDR_TX;
                        wdata_q   <= {24'h0, OUT_DATA};
                        wstrb_q   <= 4'b0001;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                     end
                  end else if (bus.RDATA[0]) begin
                     state_q   <= D_AR;
                     arvalid_q <= 1'b1;
                     araddr_q  <= ADDR_RX;
                  end else if (op_q == OP_PF) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= S_AR;
                     arvalid_q <= 1'b1;
                     araddr_q  <= ADDR_STAT;
                  end
               end
            end
            D_AR: begin
               if (bus.ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= D_R;
               end
            end
            D_R: begin
               if (bus.RVALID) begin
                  rready_q <= 1'b0;
                  if (bus.RRESP != 2'b00) err_q <= 1'b1;
                  if (op_q == OP_IN) begin
                     in_data_q <= bus.RDATA[7:0];
                     in_ack_q  <= 1'b1;
                     state_q   <= ACK;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            W_AW: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= W_B;
               end
            end
            W_B: begin
               if (bus.BVALID) begin
                  bready_q  <= 1'b0;
                  if (bus.BRESP != 2'b00) err_q <= 1'b1;
                  out_ack_q <= 1'b1;
                  state_q   <= ACK;
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Status bits other than RX valid / TX full, and the upper data lane, carry
   // nothing this block uses.
   logic unused_rdata;
   assign unused_rdata = ^{bus.RDATA[31:8], bus.RDATA[2:1]};

   assign bus.ARADDR  = araddr_q;
   assign bus.ARVALID = arvalid_q;
   assign bus.RREADY  = rready_q;
   assign bus.AWADDR  = awaddr_q;
   assign bus.AWVALID = awvalid_q;
   assign bus.WDATA   = wdata_q;
   assign bus.WSTRB   = wstrb_q;
   assign bus.WVALID  = wvalid_q;
   assign bus.BREADY  = bready_q;

   assign IN_ACK  = in_ack_q;
   assign IN_DATA = in_data_q;
   assign OUT_ACK = out_ack_q;
   assign BUSY    = (state_q != IDLE);
   assign ERR     = err_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl with a small behavioural AXI4-Lite UART slave.
module tb_uart_io_ctrl;

   logic       CLK;
   logic       RST_N;
   logic       IN_REQ;
   logic       IN_ACK;
   logic [7:0] IN_DATA;
   logic       OUT_REQ;
   logic [7:0] OUT_DATA;
   logic       OUT_ACK;
   logic       BUSY;
   logic       ERR;
   logic [2:0] RX_LEVEL;

   uart_io_ctrl_if bus();

   uart_io_ctrl #(.FIFO_DEPTH(4)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .IN_REQ   (IN_REQ),
      .IN_ACK   (IN_ACK),
      .IN_DATA  (IN_DATA),
      .OUT_REQ  (OUT_REQ),
      .OUT_DATA (OUT_DATA),
      .OUT_ACK  (OUT_ACK),
      .BUSY     (BUSY),
      .ERR      (ERR),
      .RX_LEVEL (RX_LEVEL),
      .bus      (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- UART slave model ----------------
   logic [7:0]  stat_q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  stat_dflt  = 8'h00;
   logic [1:0]  rresp_stat = 2'b00;
   logic        awready_cfg = 1'b1;
   int          ar_cnt = 0, stat_cnt = 0, wr_cnt = 0, out_ack_cnt = 0;
   logic        aw_got, w_got;
   logic [3:0]  aw_addr_seen;
   logic [31:0] wdata_seen;
   logic [3:0]  wstrb_seen;

   assign bus.ARREADY = 1'b1;
   assign bus.AWREADY = awready_cfg;
   assign bus.WREADY  = 1'b1;

   always @(posedge CLK) begin
      if (!RST_N) begin
         bus.RVALID <= 1'b0;
         bus.RDATA  <= 32'h0;
         bus.RRESP  <= 2'b00;
         bus.BVALID <= 1'b0;
         bus.BRESP  <= 2'b00;
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
      end else begin
         if (bus.ARVALID && bus.ARREADY) begin
            ar_cnt     <= ar_cnt + 1;
            bus.RVALID <= 1'b1;
            if (bus.ARADDR == 4'h8) begin
               stat_cnt  <= stat_cnt + 1;
               bus.RRESP <= rresp_stat;
               if (stat_q.size() != 0) bus.RDATA <= {24'h0, stat_q.pop_front()};
               else                    bus.RDATA <= {24'h0, stat_dflt};
            end else begin
               bus.RRESP <= 2'b00;
               if (rx_q.size() != 0) bus.RDATA <= {24'h0, rx_q.pop_front()};
               else                  bus.RDATA <= 32'hEE;
            end
         end else if (bus.RVALID && bus.RREADY) begin
            bus.RVALID <= 1'b0;
         end
         if (bus.AWVALID && bus.AWREADY) begin
            aw_addr_seen <= bus.AWADDR;
            aw_got       <= 1'b1;
         end
         if (bus.WVALID && bus.WREADY) begin
            wdata_seen <= bus.WDATA;
            wstrb_seen <= bus.WSTRB;
            w_got      <= 1'b1;
         end
         if ((aw_got || (bus.AWVALID && bus.AWREADY)) &&
             (w_got || (bus.WVALID && bus.WREADY)) && !bus.BVALID) begin
            bus.BVALID <= 1'b1;
            bus.BRESP  <= 2'b00;
            wr_cnt     <= wr_cnt + 1;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
         end else if (bus.BVALID && bus.BREADY) begin
            bus.BVALID <= 1'b0;
         end
      end
   end

   always @(posedge CLK) if (RST_N && OUT_ACK) out_ack_cnt <= out_ack_cnt + 1;

   // ---------------- core-side request tasks ----------------
   task automatic do_out(input logic [7:0] d, output int lat);
      OUT_DATA = d;
      OUT_REQ  = 1'b1;
      lat = 0;
      while (lat < 300) begin
         @(posedge CLK); #1;
         lat++;
         if (OUT_ACK) break;
      end
      check("out_ack_seen", OUT_ACK, 1);
      @(posedge CLK); #1;
      OUT_REQ = 1'b0;
      check("out_ack_pulse", OUT_ACK, 0);
   endtask

   task automatic do_in(output int lat);
      IN_REQ = 1'b1;
      lat = 0;
      while (lat < 300) begin
         @(posedge CLK); #1;
         lat++;
         if (IN_ACK) break;
      end
      check("in_ack_seen", IN_ACK, 1);
      @(posedge CLK); #1;
      IN_REQ = 1'b0;
      check("in_ack_pulse", IN_ACK, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (BUSY && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      check("idle_reached", BUSY, 0);
   endtask

   int lat, ar0, st0, wr0, ack0, n;

   initial begin
      RST_N = 1'b0; IN_REQ = 1'b0; OUT_REQ = 1'b0; OUT_DATA = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy",    BUSY, 0);
      check("rst_err",     ERR, 0);
      check("rst_arvalid", bus.ARVALID, 0);
      check("rst_awvalid", bus.AWVALID, 0);
      check("rst_wvalid",  bus.WVALID, 0);
      check("rst_araddr",  bus.ARADDR, 0);
      check("rst_wdata",   bus.WDATA, 0);
      check("rst_in_data", IN_DATA, 0);
      check("rst_level",   RX_LEVEL, 0);
      RST_N = 1'b1;

`ifdef UART_RX_PREFETCH_EN
      // Background prefetch fills the FIFO; buffered INs take one cycle.
      rx_q.push_back(8'h31); rx_q.push_back(8'h32);
      stat_q.push_back(8'h01); stat_q.push_back(8'h01);
      n = 0;
      while (RX_LEVEL != 3'd2 && n < 200) begin @(posedge CLK); #1; n++; end
      check("pf_level2", RX_LEVEL, 2);
      wait_idle();
      ar0 = ar_cnt;
      do_in(lat);
      check("pf_in1_lat",  lat, 1);
      check("pf_in1_data", IN_DATA, 8'h31);
      check("pf_in1_noax", ar_cnt, ar0);
      wait_idle();
      ar0 = ar_cnt;
      do_in(lat);
      check("pf_in2_lat",  lat, 1);
      check("pf_in2_data", IN_DATA, 8'h32);
      check("pf_in2_noax", ar_cnt, ar0);
      // Fill to capacity: prefetch must stop, then resume after a pop.
      for (int i = 0; i < 4; i++) begin
         rx_q.push_back(8'hA0 + 8'(i));
         stat_q.push_back(8'h01);
      end
      n = 0;
      while (RX_LEVEL != 3'd4 && n < 300) begin @(posedge CLK); #1; n++; end
      check("pf_level4", RX_LEVEL, 4);
      ar0 = ar_cnt;
      repeat (10) @(posedge CLK);
      #1;
      check("pf_full_noax", ar_cnt, ar0);
      check("pf_full_busy", BUSY, 0);
      do_in(lat);
      check("pf_full_data", IN_DATA, 8'hA0);
      n = 0;
      while (ar_cnt == ar0 && n < 50) begin @(posedge CLK); #1; n++; end
      check("pf_resume", 32'(ar_cnt != ar0), 1);
`else
      // Idle without requests: no AXI traffic.
      repeat (10) @(posedge CLK);
      #1;
      check("idle_no_ar", ar_cnt, 0);
      check("idle_busy",  BUSY, 0);

      // Simple OUT, TX not full.
      wr0 = wr_cnt;
      do_out(8'h41, lat);
      check("out1_lat",    lat, 5);
      check("out1_awaddr", aw_addr_seen, 4);
      check("out1_wdata",  wdata_seen, 32'h41);
      check("out1_wstrb",  wstrb_seen, 1);
      check("out1_wr",     wr_cnt - wr0, 1);
      check("out1_busy",   BUSY, 0);

      // OUT with TX full three times.
      stat_q.push_back(8'h08); stat_q.push_back(8'h08);
      stat_q.push_back(8'h08); stat_q.push_back(8'h00);
      st0 = stat_cnt; wr0 = wr_cnt; ack0 = out_ack_cnt;
      do_out(8'h5A, lat);
      check("out2_stat", stat_cnt - st0, 4);
      check("out2_wr",   wr_cnt - wr0, 1);
      check("out2_ack",  out_ack_cnt - ack0, 1);
      check("out2_data", wdata_seen, 32'h5A);
      check("out2_lat",  lat, 11);

      // Unbuffered IN, RX already valid.
      stat_q.push_back(8'h01); rx_q.push_back(8'h37);
      ar0 = ar_cnt;
      do_in(lat);
      check("in1_lat",  lat, 5);
      check("in1_data", IN_DATA, 8'h37);
      check("in1_ar",   ar_cnt - ar0, 2);

      // Unbuffered IN with two empty polls first.
      stat_q.push_back(8'h00); stat_q.push_back(8'h00); stat_q.push_back(8'h01);
      rx_q.push_back(8'h99);
      ar0 = ar_cnt;
      do_in(lat);
      check("in2_lat",   lat, 9);
      check("in2_data",  IN_DATA, 8'h99);
      check("in2_ar",    ar_cnt - ar0, 4);
      check("in2_level", RX_LEVEL, 0);
`endif

      // Error response on the status read: completes, ERR sticks.
      wait_idle();
      rresp_stat = 2'b10;
      wr0 = wr_cnt;
      do_out(8'h55, lat);
      rresp_stat = 2'b00;
      check("err_set",  ERR, 1);
      check("err_wr",   wr_cnt - wr0, 1);
      wait_idle();
      do_out(8'h66, lat);
      check("err_stick", ERR, 1);
      check("err_wdata", wdata_seen, 32'h66);

      // AW stalled: W drops alone; then reset mid-transaction.
      wait_idle();
      awready_cfg = 1'b0;
      OUT_DATA = 8'h77;
      OUT_REQ  = 1'b1;
      n = 0;
      while (!bus.AWVALID && n < 100) begin @(posedge CLK); #1; n++; end
      check("aw_rise",  bus.AWVALID, 1);
      check("w_rise",   bus.WVALID, 1);
      @(posedge CLK); #1;
      check("w_drop",   bus.WVALID, 0);
      check("aw_hold",  bus.AWVALID, 1);
      check("w_data77", wdata_seen, 32'h77);
      RST_N   = 1'b0;
      OUT_REQ = 1'b0;
      @(posedge CLK); #1;
      check("mrst_awvalid", bus.AWVALID, 0);
      check("mrst_busy",    BUSY, 0);
      check("mrst_err",     ERR, 0);
      check("mrst_awaddr",  bus.AWADDR, 0);
      check("mrst_wdata",   bus.WDATA, 0);
      check("mrst_wstrb",   bus.WSTRB, 0);
      check("mrst_in_data", IN_DATA, 0);
      check("mrst_level",   RX_LEVEL, 0);
      awready_cfg = 1'b1;
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_io_ctrl.md
# uart_io_ctrl

Sequencer between the core's `in`/`out` instructions and the AXI4-Lite UART.
- Accepts one-byte read/write requests from the core over a req/ack pair.
- Performs the status-poll → data-access sequence on the AXI4-Lite master port.
- Optionally prefetches received bytes into a small RX FIFO, so `in` completes in one cycle when data is already buffered.
- Replaces the inline polling logic in the core top; the core stalls on `BUSY`/ack instead.

## Interface
Parameters:
- FIFO_DEPTH, 4, RX prefetch FIFO entries; power of two, 2..16.
- LW, $clog2(FIFO_DEPTH)+1, level/pointer width (derived, do not override).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- IN_REQ  in  1  core requests one RX byte; held until IN_ACK.
- IN_ACK  out  1  one-cycle pulse; IN_DATA valid this cycle.
- IN_DATA  out  8  received byte; held until next IN_ACK.
- OUT_REQ  in  1  core requests TX of OUT_DATA; held until OUT_ACK.
- OUT_DATA  in  8  byte to transmit; stable while OUT_REQ.
- OUT_ACK  out  1  one-cycle pulse after write response.
- BUSY  out  1  FSM not in IDLE.
- ERR  out  1  sticky; set on any nonzero RRESP/BRESP.
- RX_LEVEL  out  LW  FIFO occupancy.
- ARADDR out 4, ARVALID out 1, ARREADY in 1: read address channel.
- RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1: read data channel.
- AWADDR out 4, AWVALID out 1, AWREADY in 1: write address channel.
- WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1: write data channel.
- BRESP in 2, BVALID in 1, BREADY out 1: write response channel.

## Operation
- UART map:
  - 0x0 RX data.
  - 0x4 TX data.
  - 0x8 status: bit0 = RX valid, bit3 = TX full.
- States:
  - IDLE.
  - S_AR, S_R: status read.
  - D_AR, D_R: RX data read.
  - W_AW: AW and W concurrent.
  - W_B.
  - ACK.
- IDLE priority, evaluated each cycle: OUT_REQ > IN_REQ > prefetch.
- IN_REQ with FIFO non-empty: pop the head into IN_DATA, pulse IN_ACK next cycle, stay in IDLE. No AXI traffic.
- IN_REQ with FIFO empty:
  - S_AR → S_R.
  - If RDATA[0]=0, return to S_AR (re-poll).
  - Else D_AR → D_R; on R handshake, IN_DATA ← RDATA[7:0] → ACK (IN_ACK=1) → IDLE.
- OUT_REQ:
  - S_AR → S_R.
  - If RDATA[3]=1, return to S_AR.
  - Else W_AW: AWADDR=4'h4, WDATA={24'b0,OUT_DATA}, WSTRB=4'b0001.
  - → W_B → ACK (OUT_ACK=1) → IDLE.
- Prefetch (macro-enabled only): in IDLE with no request and FIFO not full:
  - S_AR → S_R.
  - RDATA[0]=0 → IDLE.
  - RDATA[0]=1 → D_AR → D_R; push RDATA[7:0] on R handshake → IDLE.
  - A started prefetch always completes; core requests wait.
- FIFO: push occurs only in D_R (prefetch), pop only in IDLE. Simultaneous push/pop is impossible by construction. Push never happens when full; pop never happens when empty.
- ERR: a nonzero response is still treated as complete (data used as-is); ERR latches 1 until reset.

## Timing
- Reset: every output 0, including ARADDR, AWADDR, WDATA, WSTRB, IN_DATA and RX_LEVEL. FIFO emptied; state IDLE.
- Reset mid-transaction: all VALID/READY drop the next cycle; the slave is reset by the same RST_N.
- AR: ARVALID asserted on entering S_AR/D_AR (ARADDR 8/0 stable). Held until ARREADY; deasserts the cycle after the handshake.
- R: RREADY=1 throughout S_R/D_R; transition on RVALID.
- W_AW:
  - AWVALID and WVALID rise together.
  - Each drops independently the cycle after its own ready.
  - Leave W_AW once both have handshaken, including when they do so on the same cycle.
- B: BREADY=1 in W_B; transition on BVALID.
- Buffered IN latency: IN_REQ sampled at edge t → IN_ACK high during cycle t+1.
- OUT latency, all slave readies immediate, TX not full: OUT_REQ sampled at t → ACK high during t+5 → IDLE at t+6.
- Unbuffered IN latency, same conditions: ACK during t+5.
- Core must deassert REQ the cycle after ACK. IDLE does not resample until the cycle after ACK.
- RX_LEVEL updates the cycle after a push/pop.

## Configuration
- UART_RX_PREFETCH_EN defined: background prefetch enabled; FIFO instantiated.
- UART_RX_PREFETCH_EN undefined:
  - No FIFO; RX_LEVEL tied 0.
  - IN always takes the status/data path.
  - IDLE issues no AXI traffic without a request.

## Test plan
- Reset with valids high → all outputs 0 the next cycle; BUSY=0.
- OUT_REQ, OUT_DATA=8'h41, status=0x0 → AWADDR=4, WDATA=32'h41, WSTRB=1, OUT_ACK at t+5.
- OUT_REQ with status 0x08 three times, then 0x00 → 4 status reads, exactly 1 write, one OUT_ACK.
- Prefetch on, slave supplies 0x31, 0x32 → RX_LEVEL=2; two IN_REQs → IN_DATA 0x31, then 0x32, each with 1-cycle ACK and no AXI traffic.
- FIFO full (4) → no AR issued while idle; after 1 pop, prefetch resumes.
- RRESP=2'b10 on status read → ERR=1 and stays 1; transaction completes normally.
